// File: rtl/rcservo_frame_scheduler.sv
// Frame scheduler for a bank of RC-servo PWM outputs driven from one shared frame counter.
// Optional slew limiting of width changes is compiled in with `define RCSERVO_SLEW_EN.
`timescale 1ns/1ps

module rcservo_frame_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int FRAME_TICKS  = 480000,
    parameter int CENTER_TICKS = 72000,
    parameter int MIN_TICKS    = 48000,
    parameter int MAX_TICKS    = 96000,
    parameter int SLEW_TICKS   = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_ch,
    input  logic [31:0]       cmd_offset,
    output logic [NUM_CH-1:0] pwm,
    output logic              frame_start,
    output logic              busy
);

    localparam int CW         = $clog2(FRAME_TICKS + 1);
    localparam int FRAME_LAST = FRAME_TICKS - NUM_CH - 1;

    localparam logic signed [32:0] CENTER_S = 33'(CENTER_TICKS);
    localparam logic signed [32:0] MIN_S    = 33'(MIN_TICKS);
    localparam logic signed [32:0] MAX_S    = 33'(MAX_TICKS);

    localparam logic [CW-1:0] CENTER_W = CW'(CENTER_TICKS);
    localparam logic [CW-1:0] MIN_W    = CW'(MIN_TICKS);
    localparam logic [CW-1:0] MAX_W    = CW'(MAX_TICKS);

    // Reject configurations where the longest pulse would not fit in the frame.
    if (MAX_TICKS >= FRAME_TICKS - NUM_CH) begin : g_bad_max
        $error("MAX_TICKS must be below FRAME_TICKS-NUM_CH");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be in 1..16");
    end
    if (SLEW_TICKS < 1) begin : g_bad_slew
        $error("SLEW_TICKS must be positive");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        FRAME  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic                cmd_fire;
    logic signed [32:0]  cmd_sum;
    logic [CW-1:0]       cmd_width;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One counter serves as the channel index in UPDATE and the frame tick in FRAME.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = rst_n;
                cnt_d     = '0;
                if (enable) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy = 1'b1;
                if (cnt_q == CW'(NUM_CH - 1)) begin
                    cnt_d   = '0;
                    state_d = FRAME;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FRAME: begin
                busy        = 1'b1;
                cmd_ready   = rst_n;
                frame_start = (cnt_q == '0);
                if (cnt_q == CW'(FRAME_LAST)) begin
                    cnt_d   = '0;
                    state_d = enable ? UPDATE : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign cmd_fire = cmd_valid && cmd_ready;

    // Sign-extend the offset so large negative commands clamp low instead of wrapping.
    always_comb begin
        cmd_sum = CENTER_S + $signed({cmd_offset[31], cmd_offset});
        if (cmd_sum < MIN_S) begin
            cmd_width = MIN_W;
        end else if (cmd_sum > MAX_S) begin
            cmd_width = MAX_W;
        end else begin
            cmd_width = cmd_sum[CW-1:0];
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CW-1:0] target_q, target_d;
        logic [CW-1:0] cur_q, cur_d;
        logic [CW-1:0] cur_step;
        logic          wr;
        logic          upd;

        assign wr  = cmd_fire && ({28'd0, cmd_ch} == 32'(gi));
        assign upd = (state_q == UPDATE) && (cnt_q == CW'(gi));

`ifdef RCSERVO_SLEW_EN
        localparam logic signed [CW:0] SLEW_S = (CW+1)'(SLEW_TICKS);
        logic signed [CW:0] diff;

        always_comb begin
            diff = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});
            if (diff > SLEW_S) begin
                cur_step = cur_q + CW'(SLEW_TICKS);
            end else if (diff < -SLEW_S) begin
                cur_step = cur_q - CW'(SLEW_TICKS);
            end else begin
                cur_step = target_q;
            end
        end
`else
        assign cur_step = target_q;
`endif

        assign target_d = wr ? cmd_width : target_q;
        assign cur_d    = upd ? cur_step : cur_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                target_q <= CENTER_W;
                cur_q    <= CENTER_W;
            end else begin
                target_q <= target_d;
                cur_q    <= cur_d;
            end
        end

        assign pwm[gi] = (state_q == FRAME) && (cnt_q < cur_q);
    end

endmodule
